// File: rtl/nor_op_scheduler_if.sv
// rtl/nor_op_scheduler_if.sv - requester and shared NOR unit signals of the NOR op scheduler
interface nor_op_scheduler_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic [1:0]       op0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [1:0]       op1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic [1:0]       grant;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic [WIDTH-1:0] nor_x;
   logic [WIDTH-1:0] nor_y;
   logic [WIDTH-1:0] nor_z;

   modport master (
      output req0, op0, a0, b0, req1, op1, a1, b1, nor_z,
      input  grant, done0, done1, result, busy, nor_x, nor_y
   );

   modport slave (
      input  req0, op0, a0, b0, req1, op1, a1, b1, nor_z,
      output grant, done0, done1, result, busy, nor_x, nor_y
   );
endinterface

// File: rtl/nor_op_scheduler.sv
// rtl/nor_op_scheduler.sv - round-robin sequencer building NOT/OR/AND/NAND from one shared NOR unit
module nor_op_scheduler #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   nor_op_scheduler_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_NOT  = 2'd0;
   localparam logic [1:0] OP_OR   = 2'd1;
   localparam logic [1:0] OP_AND  = 2'd2;
   localparam logic [1:0] OP_NAND = 2'd3;

   logic [1:0]       state;
   logic [1:0]       grant_q;
   logic [1:0]       op_q;
   logic [1:0]       step;
   logic             last_grant;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] t0;
   logic [WIDTH-1:0] t1;
   logic [WIDTH-1:0] res;

   logic             any_req;
   logic             winner;
   logic             cap_t0;
   logic             cap_t1;
   logic             last_step;
   logic [WIDTH-1:0] x_mux;
   logic [WIDTH-1:0] y_mux;

   always_comb begin
      any_req = bus.req0 | bus.req1;
      if (bus.req0 && bus.req1) begin
         winner = ~last_grant;
      end else begin
         winner = bus.req1;
      end
   end

   // Step count equals opcode+1, so the final step index is the opcode itself.
   always_comb begin
      last_step = (step == op_q);
      cap_t0    = (step == 2'd0) && (op_q != OP_NOT);
      cap_t1    = (step == 2'd1) && (op_q == OP_AND || op_q == OP_NAND);
   end

   always_comb begin
      x_mux = '0;
      y_mux = '0;
      if (state == S_EXEC) begin
         case (step)
            2'd0: begin
               x_mux = a_q;
               y_mux = (op_q == OP_OR) ? b_q : a_q;
            end
            2'd1: begin
               x_mux = (op_q == OP_OR) ? t0 : b_q;
               y_mux = (op_q == OP_OR) ? t0 : b_q;
            end
            2'd2: begin
               x_mux = t0;
               y_mux = t1;
            end
            default: begin
               x_mux = res;
               y_mux = res;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         grant_q    <= 2'b00;
         op_q       <= OP_NOT;
         step       <= 2'd0;
         last_grant <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         t0         <= '0;
         t1         <= '0;
         res        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  op_q       <= winner ? bus.op1 : bus.op0;
                  a_q        <= winner ? bus.a1 : bus.a0;
                  b_q        <= winner ? bus.b1 : bus.b0;
                  grant_q    <= winner ? 2'b10 : 2'b01;
                  last_grant <= winner;
                  step       <= 2'd0;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cap_t0) begin
                  t0 <= bus.nor_z;
               end else if (cap_t1) begin
                  t1 <= bus.nor_z;
               end else begin
                  res <= bus.nor_z;
               end
               if (last_step) begin
                  state <= S_DONE;
               end else begin
                  step <= step + 2'd1;
               end
            end
            S_DONE: begin
               grant_q <= 2'b00;
               state   <= S_IDLE;
            end
            default: begin
               grant_q <= 2'b00;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.grant  = grant_q;
   assign bus.busy   = (state == S_EXEC) || (state == S_DONE);
   assign bus.done0  = (state == S_DONE) && grant_q[0];
   assign bus.done1  = (state == S_DONE) && grant_q[1];
   assign bus.result = (state == S_DONE) ? res : '0;
   assign bus.nor_x  = x_mux;
   assign bus.nor_y  = y_mux;
endmodule

// File: tb/tb_nor_op_scheduler.sv
// tb/tb_nor_op_scheduler.sv - self-checking bench for nor_op_scheduler
module tb_nor_op_scheduler;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   last_w;
   int   w;

   logic       rq  [2];
   logic [1:0] opv [2];
   logic [3:0] av  [2];
   logic [3:0] bv  [2];

   nor_op_scheduler_if #(.WIDTH(4)) bus ();

   nor_op_scheduler #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.nor_z = ~(bus.nor_x | bus.nor_y);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      bus.req0 = rq[0];
      bus.op0  = opv[0];
      bus.a0   = av[0];
      bus.b0   = bv[0];
      bus.req1 = rq[1];
      bus.op1  = opv[1];
      bus.a1   = av[1];
      bus.b1   = bv[1];
   endtask

   function automatic logic [3:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         2'd0:    return ~a;
         2'd1:    return a | b;
         2'd2:    return a & b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic idle_chk();
      tick();
      chk("idle_grant", 4'(bus.grant), 4'h0);
      chk("idle_busy", 4'(bus.busy), 4'h0);
      chk("idle_done", 4'({bus.done1, bus.done0}), 4'h0);
      chk("idle_nor_x", bus.nor_x, 4'h0);
   endtask

   // Expects acceptance at the next edge; winner follows round-robin over the driven levels.
   task automatic transact(input bit perturb, output int win);
      logic [3:0] exp;
      int         n;
      logic       dw;
      logic       dl;
      if (rq[0] && rq[1]) win = 1 - last_w;
      else                win = rq[0] ? 0 : 1;
      exp    = model(opv[win], av[win], bv[win]);
      n      = int'(opv[win]) + 1;
      last_w = win;
      for (int c = 1; c <= n + 1; c++) begin
         tick();
         dw = (win == 1) ? bus.done1 : bus.done0;
         dl = (win == 1) ? bus.done0 : bus.done1;
         chk("grant", 4'(bus.grant), (win == 1) ? 4'h2 : 4'h1);
         chk("busy", 4'(bus.busy), 4'h1);
         chk("done_owner", 4'(dw), (c == n + 1) ? 4'h1 : 4'h0);
         chk("done_other", 4'(dl), 4'h0);
         if (c == n + 1) chk("result", bus.result, exp);
         if (c == 1 && perturb) begin
            av[win] = 4'($urandom);
            bv[win] = 4'($urandom);
            drive();
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      last_w = 1;
   endtask

   initial begin
      logic [3:0] ex_x [4];
      logic [3:0] ex_y [4];
      n_cmp  = 0;
      n_err  = 0;
      last_w = 1;
      for (int i = 0; i < 2; i++) begin
         rq[i] = 1'b0; opv[i] = 2'd0; av[i] = 4'h0; bv[i] = 4'h0;
      end
      drive();
      rst_n = 1'b0;
      #12;
      chk("rst_grant", 4'(bus.grant), 4'h0);
      chk("rst_busy", 4'(bus.busy), 4'h0);
      chk("rst_done", 4'({bus.done1, bus.done0}), 4'h0);
      chk("rst_result", bus.result, 4'h0);
      chk("rst_nor_x", bus.nor_x, 4'h0);
      chk("rst_nor_y", bus.nor_y, 4'h0);
      do_reset();

      // NAND on requester 0 with the NOR operand sequence spelled out
      ex_x[0] = 4'hC; ex_x[1] = 4'hA; ex_x[2] = 4'h3; ex_x[3] = 4'h8;
      ex_y[0] = 4'hC; ex_y[1] = 4'hA; ex_y[2] = 4'h5; ex_y[3] = 4'h8;
      rq[0] = 1'b1; opv[0] = 2'd3; av[0] = 4'hC; bv[0] = 4'hA;
      drive();
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk("nand_grant", 4'(bus.grant), 4'h1);
         if (c <= 4) begin
            chk("nand_x", bus.nor_x, ex_x[c-1]);
            chk("nand_y", bus.nor_y, ex_y[c-1]);
            chk("nand_done_early", 4'(bus.done0), 4'h0);
         end
      end
      chk("nand_done", 4'(bus.done0), 4'h1);
      chk("nand_result", bus.result, 4'h7);
      chk("nand_x_done", bus.nor_x, 4'h0);
      last_w = 0;
      rq[0] = 1'b0;
      drive();
      idle_chk();

      // OR on requester 1 alone
      rq[1] = 1'b1; opv[1] = 2'd1; av[1] = 4'hC; bv[1] = 4'hA;
      drive();
      transact(1'b0, w);
      chk("or_result", bus.result, 4'hE);
      rq[1] = 1'b0;
      drive();
      idle_chk();

      // NOT on requester 0: single NOR step
      rq[0] = 1'b1; opv[0] = 2'd0; av[0] = 4'h5; bv[0] = 4'hF;
      drive();
      tick();
      chk("not_x", bus.nor_x, 4'h5);
      chk("not_y", bus.nor_y, 4'h5);
      chk("not_done_early", 4'(bus.done0), 4'h0);
      tick();
      chk("not_done", 4'(bus.done0), 4'h1);
      chk("not_result", bus.result, 4'hA);
      chk("not_x_done", bus.nor_x, 4'h0);
      last_w = 0;
      rq[0] = 1'b0;
      drive();
      idle_chk();

      // Both requesting after reset: grants alternate while both hold req
      do_reset();
      rq[0] = 1'b1; opv[0] = 2'd2; av[0] = 4'hF; bv[0] = 4'h6;
      rq[1] = 1'b1; opv[1] = 2'd3; av[1] = 4'hF; bv[1] = 4'h6;
      drive();
      transact(1'b0, w);
      chk("both_first_result", bus.result, 4'h6);
      idle_chk();
      transact(1'b0, w);
      chk("both_second_result", bus.result, 4'h9);
      idle_chk();
      transact(1'b0, w);
      chk("both_third_grant", 4'(bus.grant), 4'h1);
      rq[0] = 1'b0; rq[1] = 1'b0;
      drive();
      idle_chk();

      // Reset pulsed during EXEC step 1 of a NAND
      rq[0] = 1'b1; opv[0] = 2'd3; av[0] = 4'hF; bv[0] = 4'h3;
      drive();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_grant", 4'(bus.grant), 4'h0);
      chk("arst_busy", 4'(bus.busy), 4'h0);
      chk("arst_nor_x", bus.nor_x, 4'h0);
      chk("arst_nor_y", bus.nor_y, 4'h0);
      tick();
      chk("arst_no_done", 4'({bus.done1, bus.done0}), 4'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      last_w = 1;
      transact(1'b0, w);
      chk("arst_reissue", bus.result, 4'hC);
      rq[0] = 1'b0;
      drive();
      idle_chk();

      // Operands changed one cycle after acceptance are ignored
      rq[0] = 1'b1; opv[0] = 2'd1; av[0] = 4'h3; bv[0] = 4'h4;
      drive();
      transact(1'b1, w);
      chk("latched_result", bus.result, 4'h7);
      rq[0] = 1'b0;
      drive();
      idle_chk();

      // Randomized traffic against the reference model
      for (int i = 0; i < 2; i++) begin
         rq[i] = 1'($urandom); opv[i] = 2'($urandom); av[i] = 4'($urandom); bv[i] = 4'($urandom);
      end
      if (!rq[0] && !rq[1]) rq[$urandom_range(1, 0)] = 1'b1;
      drive();
      for (int k = 0; k < 40; k++) begin
         transact(1'($urandom), w);
         for (int i = 0; i < 2; i++) begin
            if (i == w || !rq[i]) begin
               rq[i] = 1'($urandom); opv[i] = 2'($urandom); av[i] = 4'($urandom); bv[i] = 4'($urandom);
            end
         end
         if (!rq[0] && !rq[1]) rq[$urandom_range(1, 0)] = 1'b1;
         drive();
         idle_chk();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
